// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-access stage: FSM states, funct3 access
// encodings and the alignment rule used to route bad accesses to the trap path.
package mem_access_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned sizes exist only for loads; any unlisted encoding takes the trap path.
    function automatic logic misaligned(input logic       is_store,
                                        input logic [2:0] funct3,
                                        input logic [1:0] off);
        logic bad;
        case (funct3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = is_store;
            F3_HU:   bad = is_store | off[0];
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_align.sv
// Combinational lane logic: load byte/half extraction with sign/zero extension, and
// store data replication plus byte-strobe generation.
module mem_access_align
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      off_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] load_val_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [3:0]      wstrb_o
);

    logic [XLEN-1:0] shifted;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        case (funct3_i)
            F3_B:    load_val_o = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_H:    load_val_o = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_W:    load_val_o = rdata_i;
            F3_BU:   load_val_o = {{(XLEN-8){1'b0}}, lane_b};
            F3_HU:   load_val_o = {{(XLEN-16){1'b0}}, lane_h};
            default: load_val_o = '0;
        endcase
    end

    always_comb begin
        case (funct3_i)
            F3_B: begin
                wstrb_o = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            F3_H: begin
                wstrb_o = 4'b0011 << off_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            F3_W: begin
                wstrb_o = 4'b1111;
                wdata_o = store_data_i;
            end
            default: begin
                wstrb_o = 4'b0000;
                wdata_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready data bus, stalls
// upstream while a transaction is outstanding and registers results for write-back.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned INSTR_WIDTH = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   E_valid_i,
    input  logic [INSTR_WIDTH-1:0] E_instr_i,
    input  logic                   E_sel_reg_i,
    input  logic [XLEN-1:0]        E_valE_i,
    input  logic [XLEN-1:0]        E_store_data_i,
    input  logic                   E_mem_rd_i,
    input  logic                   E_mem_wr_i,
    input  logic [2:0]             E_funct3_i,
    output logic                   M_ready_o,
    output logic                   dmem_req_valid_o,
    input  logic                   dmem_req_ready_i,
    output logic                   dmem_req_we_o,
    output logic [XLEN-1:0]        dmem_req_addr_o,
    output logic [XLEN-1:0]        dmem_req_wdata_o,
    output logic [3:0]             dmem_req_wstrb_o,
    input  logic                   dmem_rsp_valid_i,
    input  logic [XLEN-1:0]        dmem_rsp_rdata_i,
    output logic                   MD_valid_o,
    output logic [INSTR_WIDTH-1:0] MD_instr_o,
    output logic                   MD_sel_reg_o,
    output logic [XLEN-1:0]        MD_valE_o,
    output logic [XLEN-1:0]        MD_valM_o,
    output logic                   MD_misalign_o
);

    state_e                 state_q, state_d;
    logic [INSTR_WIDTH-1:0] pend_instr_q, pend_instr_d;
    logic                   pend_sel_q, pend_sel_d;
    logic [XLEN-1:0]        pend_addr_q, pend_addr_d;
    logic [XLEN-1:0]        pend_data_q, pend_data_d;
    logic [2:0]             pend_f3_q, pend_f3_d;
    logic                   pend_wr_q, pend_wr_d;

    logic                   md_valid_q, md_valid_d;
    logic [INSTR_WIDTH-1:0] md_instr_q, md_instr_d;
    logic                   md_sel_q, md_sel_d;
    logic [XLEN-1:0]        md_vale_q, md_vale_d;
    logic [XLEN-1:0]        md_valm_q, md_valm_d;
    logic                   md_mis_q, md_mis_d;

    logic [XLEN-1:0]        load_val, wdata;
    logic [3:0]             wstrb;
    logic                   in_req;

    mem_access_align #(
        .XLEN (XLEN)
    ) u_align (
        .funct3_i     (pend_f3_q),
        .off_i        (pend_addr_q[1:0]),
        .store_data_i (pend_data_q),
        .rdata_i      (dmem_rsp_rdata_i),
        .load_val_o   (load_val),
        .wdata_o      (wdata),
        .wstrb_o      (wstrb)
    );

    always_comb begin
        state_d      = state_q;
        pend_instr_d = pend_instr_q;
        pend_sel_d   = pend_sel_q;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        pend_f3_d    = pend_f3_q;
        pend_wr_d    = pend_wr_q;
        md_valid_d   = 1'b0;
        md_instr_d   = md_instr_q;
        md_sel_d     = md_sel_q;
        md_vale_d    = md_vale_q;
        md_valm_d    = md_valm_q;
        md_mis_d     = md_mis_q;

        unique case (state_q)
            StIdle: begin
                if (E_valid_i) begin
                    if ((E_mem_rd_i || E_mem_wr_i) &&
                        !misaligned(E_mem_wr_i, E_funct3_i, E_valE_i[1:0])) begin
                        pend_instr_d = E_instr_i;
                        pend_sel_d   = E_sel_reg_i;
                        pend_addr_d  = E_valE_i;
                        pend_data_d  = E_store_data_i;
                        pend_f3_d    = E_funct3_i;
                        pend_wr_d    = E_mem_wr_i;
                        state_d      = StReq;
                    end else begin
                        // Pass-through and trap path both retire next cycle, no bus access.
                        md_valid_d = 1'b1;
                        md_instr_d = E_instr_i;
                        md_sel_d   = E_sel_reg_i;
                        md_vale_d  = E_valE_i;
                        md_valm_d  = '0;
                        md_mis_d   = E_mem_rd_i || E_mem_wr_i;
                    end
                end
            end
            StReq: begin
                if (dmem_req_ready_i) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (dmem_rsp_valid_i) begin
                    md_valid_d = 1'b1;
                    md_instr_d = pend_instr_q;
                    md_sel_d   = pend_sel_q;
                    md_vale_d  = pend_addr_q;
                    md_valm_d  = pend_wr_q ? '0 : load_val;
                    md_mis_d   = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            pend_instr_q <= '0;
            pend_sel_q   <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
            pend_f3_q    <= 3'b000;
            pend_wr_q    <= 1'b0;
            md_valid_q   <= 1'b0;
            md_instr_q   <= '0;
            md_sel_q     <= 1'b0;
            md_vale_q    <= '0;
            md_valm_q    <= '0;
            md_mis_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_instr_q <= pend_instr_d;
            pend_sel_q   <= pend_sel_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
            pend_f3_q    <= pend_f3_d;
            pend_wr_q    <= pend_wr_d;
            md_valid_q   <= md_valid_d;
            md_instr_q   <= md_instr_d;
            md_sel_q     <= md_sel_d;
            md_vale_q    <= md_vale_d;
            md_valm_q    <= md_valm_d;
            md_mis_q     <= md_mis_d;
        end
    end

    // Bus fields are driven only while requesting so idle/wait cycles show zeros.
    assign in_req           = (state_q == StReq);
    assign M_ready_o        = (state_q == StIdle);
    assign dmem_req_valid_o = in_req;
    assign dmem_req_we_o    = in_req & pend_wr_q;
    assign dmem_req_addr_o  = in_req ? {pend_addr_q[XLEN-1:2], 2'b00} : '0;
    assign dmem_req_wdata_o = (in_req && pend_wr_q) ? wdata : '0;
    assign dmem_req_wstrb_o = (in_req && pend_wr_q) ? wstrb : 4'b0000;

    assign MD_valid_o    = md_valid_q;
    assign MD_instr_o    = md_instr_q;
    assign MD_sel_reg_o  = md_sel_q;
    assign MD_valE_o     = md_vale_q;
    assign MD_valM_o     = md_valm_q;
    assign MD_misalign_o = md_mis_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, delayed-ready store, misalignment,
// reset mid-transaction and back-to-back retirement order.
module tb_mem_access;

    logic        clk;
    logic        rst;
    logic        e_valid;
    logic [31:0] e_instr;
    logic        e_sel;
    logic [31:0] e_vale;
    logic [31:0] e_sdata;
    logic        e_rd;
    logic        e_wr;
    logic [2:0]  e_f3;
    logic        m_ready;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        md_valid;
    logic [31:0] md_instr;
    logic        md_sel;
    logic [31:0] md_vale;
    logic [31:0] md_valm;
    logic        md_mis;

    int total;
    int bad;

    mem_access dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .E_valid_i        (e_valid),
        .E_instr_i        (e_instr),
        .E_sel_reg_i      (e_sel),
        .E_valE_i         (e_vale),
        .E_store_data_i   (e_sdata),
        .E_mem_rd_i       (e_rd),
        .E_mem_wr_i       (e_wr),
        .E_funct3_i       (e_f3),
        .M_ready_o        (m_ready),
        .dmem_req_valid_o (req_valid),
        .dmem_req_ready_i (req_ready),
        .dmem_req_we_o    (req_we),
        .dmem_req_addr_o  (req_addr),
        .dmem_req_wdata_o (req_wdata),
        .dmem_req_wstrb_o (req_wstrb),
        .dmem_rsp_valid_i (rsp_valid),
        .dmem_rsp_rdata_i (rsp_rdata),
        .MD_valid_o       (md_valid),
        .MD_instr_o       (md_instr),
        .MD_sel_reg_o     (md_sel),
        .MD_valE_o        (md_vale),
        .MD_valM_o        (md_valm),
        .MD_misalign_o    (md_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic sel, input logic [31:0] vale,
                           input logic [31:0] sdata, input logic rd, input logic wr,
                           input logic [2:0] f3);
        e_valid = 1'b1;
        e_instr = instr;
        e_sel   = sel;
        e_vale  = vale;
        e_sdata = sdata;
        e_rd    = rd;
        e_wr    = wr;
        e_f3    = f3;
    endtask

    task automatic idle_inputs();
        e_valid = 1'b0;
        e_rd    = 1'b0;
        e_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (m_ready !== 1'b1 || req_valid !== 1'b0 || req_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: ready=%b req_valid=%b we=%b want 1 0 0",
                     m_ready, req_valid, req_we);
        end
        total++;
        if (req_addr !== 32'h0 || req_wdata !== 32'h0 || req_wstrb !== 4'h0) begin
            bad++;
            $display("FAIL reset_req: addr=%h wdata=%h wstrb=%b want zeros",
                     req_addr, req_wdata, req_wstrb);
        end
        total++;
        if (md_valid !== 1'b0 || md_instr !== 32'h0 || md_sel !== 1'b0 || md_vale !== 32'h0 ||
            md_valm !== 32'h0 || md_mis !== 1'b0) begin
            bad++;
            $display("FAIL reset_md: valid=%b instr=%h sel=%b valE=%h valM=%h mis=%b want zeros",
                     md_valid, md_instr, md_sel, md_vale, md_valm, md_mis);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_passthrough();
        logic [31:0] instrs [2];
        logic [31:0] vals   [2];
        logic        sels   [2];
        instrs[0] = 32'h002081B3; vals[0] = 32'h0000_1234; sels[0] = 1'b1;
        instrs[1] = 32'h0010_0073; vals[1] = 32'hCAFE_0001; sels[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            present(instrs[i], sels[i], vals[i], 32'h5555_5555, 1'b0, 1'b0, 3'b000);
            step();
            idle_inputs();
            total++;
            if (md_valid !== 1'b1 || md_instr !== instrs[i] || md_vale !== vals[i] ||
                md_sel !== sels[i] || md_valm !== 32'h0 || md_mis !== 1'b0) begin
                bad++;
                $display("FAIL pass_%0d: valid=%b instr=%h valE=%h sel=%b valM=%h mis=%b want 1 %h %h %b 0 0",
                         i, md_valid, md_instr, md_vale, md_sel, md_valm, md_mis,
                         instrs[i], vals[i], sels[i]);
            end
            total++;
            if (req_valid !== 1'b0 || m_ready !== 1'b1) begin
                bad++;
                $display("FAIL pass_bus_%0d: req_valid=%b ready=%b want 0 1", i, req_valid, m_ready);
            end
            step();
            total++;
            if (md_valid !== 1'b0 || md_vale !== vals[i]) begin
                bad++;
                $display("FAIL pass_hold_%0d: valid=%b valE=%h want 0 %h",
                         i, md_valid, md_vale, vals[i]);
            end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s  [6];
        logic [31:0] adrs [6];
        logic [31:0] exps [6];
        f3s[0] = 3'b000; adrs[0] = 32'h103; exps[0] = 32'hFFFF_FF80;
        f3s[1] = 3'b100; adrs[1] = 32'h103; exps[1] = 32'h0000_0080;
        f3s[2] = 3'b001; adrs[2] = 32'h102; exps[2] = 32'hFFFF_80FF;
        f3s[3] = 3'b101; adrs[3] = 32'h102; exps[3] = 32'h0000_80FF;
        f3s[4] = 3'b000; adrs[4] = 32'h101; exps[4] = 32'h0000_0011;
        f3s[5] = 3'b010; adrs[5] = 32'h100; exps[5] = 32'h80FF_1122;
        for (int i = 0; i < 6; i++) begin
            present(32'h0000_0003 | (32'(i) << 20), 1'b0, adrs[i], 32'h0, 1'b1, 1'b0, f3s[i]);
            step();
            idle_inputs();
            total++;
            if (req_valid !== 1'b1 || req_addr !== 32'h100 || req_wstrb !== 4'b0000 ||
                req_we !== 1'b0 || m_ready !== 1'b0) begin
                bad++;
                $display("FAIL load_req_%0d: valid=%b addr=%h wstrb=%b we=%b ready=%b want 1 100 0000 0 0",
                         i, req_valid, req_addr, req_wstrb, req_we, m_ready);
            end
            req_ready = 1'b1;
            step();
            req_ready = 1'b0;
            rsp_valid = 1'b1;
            rsp_rdata = 32'h80FF_1122;
            step();
            rsp_valid = 1'b0;
            total++;
            if (md_valid !== 1'b1 || md_valm !== exps[i] || md_vale !== adrs[i] || md_mis !== 1'b0) begin
                bad++;
                $display("FAIL load_val_%0d: valid=%b valM=%h valE=%h mis=%b want 1 %h %h 0",
                         i, md_valid, md_valm, md_vale, md_mis, exps[i], adrs[i]);
            end
            step();
        end
    endtask

    task automatic test_store_delayed();
        present(32'h0020_9123, 1'b0, 32'h202, 32'hABCD_BEEF, 1'b0, 1'b1, 3'b001);
        step();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            total++;
            if (req_valid !== 1'b1 || req_we !== 1'b1 || req_addr !== 32'h200 ||
                req_wdata !== 32'hBEEF_BEEF || req_wstrb !== 4'b1100 || m_ready !== 1'b0) begin
                bad++;
                $display("FAIL store_hold_%0d: v=%b we=%b addr=%h wdata=%h wstrb=%b ready=%b",
                         c, req_valid, req_we, req_addr, req_wdata, req_wstrb, m_ready);
            end
            step();
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        total++;
        if (req_valid !== 1'b0 || m_ready !== 1'b0 || md_valid !== 1'b0) begin
            bad++;
            $display("FAIL store_wait: req_valid=%b ready=%b md_valid=%b want 0 0 0",
                     req_valid, m_ready, md_valid);
        end
        rsp_valid = 1'b1;
        step();
        rsp_valid = 1'b0;
        total++;
        if (md_valid !== 1'b1 || m_ready !== 1'b1 || md_vale !== 32'h202 || md_mis !== 1'b0 ||
            md_instr !== 32'h0020_9123) begin
            bad++;
            $display("FAIL store_retire: valid=%b ready=%b valE=%h mis=%b instr=%h",
                     md_valid, m_ready, md_vale, md_mis, md_instr);
        end
        step();
    endtask

    task automatic test_misaligned();
        present(32'h0000_A103, 1'b0, 32'h101, 32'h0, 1'b1, 1'b0, 3'b010);
        step();
        idle_inputs();
        total++;
        if (md_valid !== 1'b1 || md_mis !== 1'b1 || md_valm !== 32'h0 || req_valid !== 1'b0 ||
            m_ready !== 1'b1) begin
            bad++;
            $display("FAIL misalign_lw: valid=%b mis=%b valM=%h req_valid=%b ready=%b want 1 1 0 0 1",
                     md_valid, md_mis, md_valm, req_valid, m_ready);
        end
        present(32'h0000_B023, 1'b0, 32'h203, 32'h1, 1'b0, 1'b1, 3'b100);
        step();
        idle_inputs();
        total++;
        if (md_valid !== 1'b1 || md_mis !== 1'b1 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_badf3: valid=%b mis=%b req_valid=%b want 1 1 0",
                     md_valid, md_mis, req_valid);
        end
        step();
        total++;
        if (md_valid !== 1'b0 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL misalign_after: valid=%b req_valid=%b want 0 0", md_valid, req_valid);
        end
    endtask

    task automatic test_reset_mid();
        present(32'h0000_2003, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 3'b010);
        step();
        idle_inputs();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst = 1'b1;
        #1;
        total++;
        if (md_vale !== 32'h0 || md_valid !== 1'b0 || m_ready !== 1'b1 || req_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: valE=%h valid=%b ready=%b req_valid=%b want 0 0 1 0",
                     md_vale, md_valid, m_ready, req_valid);
        end
        step();
        rst = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'h1234_5678;
        step();
        rsp_valid = 1'b0;
        total++;
        if (md_valid !== 1'b0 || md_valm !== 32'h0 || m_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_late_rsp: valid=%b valM=%h ready=%b want 0 0 1",
                     md_valid, md_valm, m_ready);
        end
        present(32'h0031_01B3, 1'b1, 32'h0000_0777, 32'h0, 1'b0, 1'b0, 3'b000);
        step();
        idle_inputs();
        total++;
        if (md_valid !== 1'b1 || md_vale !== 32'h0000_0777) begin
            bad++;
            $display("FAIL rst_next: valid=%b valE=%h want 1 00000777", md_valid, md_vale);
        end
        step();
    endtask

    task automatic test_back_to_back();
        present(32'h0000_2283, 1'b0, 32'h300, 32'h0, 1'b1, 1'b0, 3'b010);
        step();
        present(32'h0041_8233, 1'b1, 32'h0000_00AA, 32'h0, 1'b0, 1'b0, 3'b000);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rsp_valid = 1'b1;
        rsp_rdata = 32'hDEAD_BEEF;
        total++;
        if (m_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_stall: ready=%b want 0", m_ready);
        end
        step();
        rsp_valid = 1'b0;
        total++;
        if (md_valid !== 1'b1 || md_instr !== 32'h0000_2283 || md_valm !== 32'hDEAD_BEEF ||
            md_sel !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: valid=%b instr=%h valM=%h sel=%b want 1 00002283 deadbeef 0",
                     md_valid, md_instr, md_valm, md_sel);
        end
        step();
        idle_inputs();
        total++;
        if (md_valid !== 1'b1 || md_instr !== 32'h0041_8233 || md_vale !== 32'h0000_00AA ||
            md_valm !== 32'h0 || md_sel !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: valid=%b instr=%h valE=%h valM=%h sel=%b",
                     md_valid, md_instr, md_vale, md_valm, md_sel);
        end
        step();
        total++;
        if (md_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: valid=%b want 0", md_valid);
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b0;
        e_valid   = 1'b0;
        e_instr   = '0;
        e_sel     = 1'b0;
        e_vale    = '0;
        e_sdata   = '0;
        e_rd      = 1'b0;
        e_wr      = 1'b0;
        e_f3      = 3'b000;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_rdata = '0;
        test_reset();
        test_passthrough();
        test_loads();
        test_store_delayed();
        test_misaligned();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
